decoder_select_arbiter: RTL and testbench

- Round-robin arbiter that shares one 3-to-8 inverted-output decoder (ttl_74138) among WIDTH_OUT requesters.
- Drives the decoder's select and enable inputs so that exactly one active-low select line is asserted for the current owner.
- Limits each tenure to MAX_HOLD cycles and inserts a guard interval, with the decoder disabled, between owners.
- Sits between bus masters and the chip-select fabric built from the decoder.

---
 rtl/decoder_select_arbiter_pkg.sv | 37 +++
 rtl/decoder_select_arbiter_if.sv | 26 ++
 rtl/decoder_select_arbiter_ttl_74138.sv | 33 +++
 rtl/decoder_select_arbiter.sv | 130 +++++++++++++
 tb/tb_decoder_select_arbiter.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/decoder_select_arbiter_pkg.sv
// Shared definitions for the decoder select arbiter: FSM state encoding and
// a circular priority search that other round-robin arbiters can reuse.
package decoder_select_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GUARD = 2'd2
   } state_t;

   // Widest request vector the search function handles.
   localparam int MAX_REQ   = 32;
   localparam int MAX_REQ_W = $clog2(MAX_REQ);

   // Returns the first set index scanning ptr, ptr+1, ..., n-1, 0, ..., ptr-1,
   // or -1 when no bit below n is set. ptr must be below n.
   function automatic int rr_search(input logic [MAX_REQ-1:0] req,
                                    input int ptr,
                                    input int n);
      int result;
      int idx;
      result = -1;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (k < n) begin
            idx = ptr + k;
            if (idx >= n) begin
               idx = idx - n;
            end
            if (req[idx[MAX_REQ_W-1:0]]) begin
               result = idx;
            end
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/decoder_select_arbiter_if.sv
// Bus between the requesting masters and the arbiter: requests in, decoder
// control and decoded active-low selects out.
interface decoder_select_arbiter_if #(
   parameter int WIDTH_OUT = 8,
   parameter int WIDTH_IN  = $clog2(WIDTH_OUT)
);

   logic [WIDTH_OUT-1:0] Request;
   logic [WIDTH_IN-1:0]  A;
   logic                 Enable1_bar;
   logic                 Enable2_bar;
   logic                 Enable3;
   logic                 Active;
   logic [WIDTH_OUT-1:0] Select_bar;

   modport master (
      output Request,
      input  A, Enable1_bar, Enable2_bar, Enable3, Active, Select_bar
   );

   modport slave (
      input  Request,
      output A, Enable1_bar, Enable2_bar, Enable3, Active, Select_bar
   );

endinterface

// File: rtl/decoder_select_arbiter_ttl_74138.sv
// Generic 74138-style decoder: with both active-low enables low and the
// active-high enable high, output line A is driven low; otherwise all high.
module ttl_74138 #(
   parameter int WIDTH_OUT  = 8,
   parameter int WIDTH_IN   = $clog2(WIDTH_OUT),
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic                 Enable1_bar,
   input  logic                 Enable2_bar,
   input  logic                 Enable3,
   input  logic [WIDTH_IN-1:0]  A,
   output logic [WIDTH_OUT-1:0] Select_bar
);

   logic enabled;
   logic delay_unused;

   assign enabled = !Enable1_bar && !Enable2_bar && Enable3;

   // Rise/fall delays are timing annotation for board-level models only;
   // the synthesized decoder is zero-delay logic.
   assign delay_unused = (DELAY_RISE != 0) || (DELAY_FALL != 0);

   // Pull exactly the addressed line low while the decoder is enabled.
   always_comb begin
      Select_bar = '1;
      if (enabled) begin
         Select_bar[A] = 1'b0;
      end
   end

endmodule

// File: rtl/decoder_select_arbiter.sv
// Round-robin arbiter sharing one 74138 decoder among WIDTH_OUT requesters.
// Each tenure lasts 1..MAX_HOLD cycles and is followed by GUARD_CYCLES of
// decoder-disabled time so two owners never overlap on the select lines.
module decoder_select_arbiter
   import decoder_select_arbiter_pkg::*;
#(
   parameter int WIDTH_OUT    = 8,
   parameter int WIDTH_IN     = $clog2(WIDTH_OUT),
   parameter int MAX_HOLD     = 4,
   parameter int GUARD_CYCLES = 1,
   parameter int DELAY_RISE   = 0,
   parameter int DELAY_FALL   = 0
) (
   input logic                    Clk,
   input logic                    Clear_bar,
   decoder_select_arbiter_if.slave bus
);

   localparam int HOLD_W  = $clog2(MAX_HOLD + 1);
   localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);

   state_t               state_q, state_d;
   logic [WIDTH_IN-1:0]  a_q, a_d;
   logic [WIDTH_IN-1:0]  ptr_q, ptr_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic [GUARD_W-1:0]   guard_q, guard_d;
   logic                 grant_q;

   int                   win_int;
   logic                 win_found;
   logic [WIDTH_IN-1:0]  win_idx;

   logic                 en1_bar;
   logic                 en2_bar;
   logic                 en3;

   // Circular search for the next owner starting at the round-robin pointer.
   always_comb begin
      win_int   = rr_search(MAX_REQ'(bus.Request), int'(ptr_q), WIDTH_OUT);
      win_found = (win_int >= 0);
      win_idx   = WIDTH_IN'(win_int);
   end

   // Next-state logic: pick an owner, time its tenure, then run the guard gap.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      guard_d = guard_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = GRANT;
               a_d     = win_idx;
               hold_d  = '0;
            end
         end
         GRANT: begin
            if (!bus.Request[a_q] || (hold_q == HOLD_W'(MAX_HOLD - 1))) begin
               state_d = GUARD;
               guard_d = '0;
               ptr_d   = (a_q == WIDTH_IN'(WIDTH_OUT - 1)) ? '0 : a_q + WIDTH_IN'(1);
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         GUARD: begin
            if (guard_q == GUARD_W'(GUARD_CYCLES - 1)) begin
               if (win_found) begin
                  state_d = GRANT;
                  a_d     = win_idx;
                  hold_d  = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               guard_d = guard_q + GUARD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, owner, pointer and counters; grant_q is a dedicated flop so the
   // decoder enables come straight from a register and cannot glitch.
   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) begin
         state_q <= IDLE;
         a_q     <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
         guard_q <= '0;
         grant_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         guard_q <= guard_d;
         grant_q <= (state_d == GRANT);
      end
   end

   assign en1_bar = ~grant_q;
   assign en2_bar = ~grant_q;
   assign en3     = grant_q;

   assign bus.A           = a_q;
   assign bus.Enable1_bar = en1_bar;
   assign bus.Enable2_bar = en2_bar;
   assign bus.Enable3     = en3;
   assign bus.Active      = grant_q;

   ttl_74138 #(
      .WIDTH_OUT  (WIDTH_OUT),
      .WIDTH_IN   (WIDTH_IN),
      .DELAY_RISE (DELAY_RISE),
      .DELAY_FALL (DELAY_FALL)
   ) u_decoder (
      .Enable1_bar (en1_bar),
      .Enable2_bar (en2_bar),
      .Enable3     (en3),
      .A           (a_q),
      .Select_bar  (bus.Select_bar)
   );

endmodule

// File: tb/tb_decoder_select_arbiter.sv
// Directed bench for decoder_select_arbiter: table-driven steady-state
// sequences plus hand-written reset, early-release and idle/wrap sequences.
module tb_decoder_select_arbiter;

   logic Clk;
   logic Clear_bar;
   int   total;
   int   bad;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic [7:0] sel;
      logic [2:0] a;
      logic       act;
   } vec_t;

   vec_t vecs[23];

   decoder_select_arbiter_if #(.WIDTH_OUT(8), .WIDTH_IN(3)) bus ();

   decoder_select_arbiter #(
      .WIDTH_OUT    (8),
      .WIDTH_IN     (3),
      .MAX_HOLD     (4),
      .GUARD_CYCLES (1),
      .DELAY_RISE   (0),
      .DELAY_FALL   (0)
   ) dut (
      .Clk       (Clk),
      .Clear_bar (Clear_bar),
      .bus       (bus)
   );

   // Free-running 10-unit clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check_output(input string name, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_invariant();
      int zeros;
      zeros = $countones(~bus.Select_bar);
      check_output("inv_onehot", 8'(zeros <= 1), 8'd1);
      check_output("inv_active", 8'(bus.Active), 8'(bus.Select_bar != 8'hFF));
   endtask

   task automatic check_state(input string name, input logic [7:0] sel,
                              input logic [2:0] a, input logic act);
      check_output({name, "_sel"}, bus.Select_bar, sel);
      check_output({name, "_a"}, 8'(bus.A), 8'(a));
      check_output({name, "_act"}, 8'(bus.Active), 8'(act));
   endtask

   task automatic apply_stimulus(input logic [7:0] req);
      bus.Request = req;
      @(posedge Clk);
      #1;
      check_invariant();
   endtask

   task automatic do_reset(input logic [7:0] req_after);
      Clear_bar   = 1'b0;
      bus.Request = 8'($urandom);
      repeat (3) @(posedge Clk);
      #1;
      check_state("reset", 8'hFF, 3'd0, 1'b0);
      check_output("reset_en1", 8'(bus.Enable1_bar), 8'd1);
      check_output("reset_en2", 8'(bus.Enable2_bar), 8'd1);
      check_output("reset_en3", 8'(bus.Enable3), 8'd0);
      check_invariant();
      bus.Request = req_after;
      #2;
      Clear_bar = 1'b1;
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      Clear_bar   = 1'b0;
      bus.Request = 8'h00;

      // Sole holder 3: four grant cycles, one guard cycle, repeat.
      vecs[0]  = '{1'b1, 8'h08, 8'hF7, 3'd3, 1'b1};
      vecs[1]  = '{1'b0, 8'h08, 8'hF7, 3'd3, 1'b1};
      vecs[2]  = '{1'b0, 8'h08, 8'hF7, 3'd3, 1'b1};
      vecs[3]  = '{1'b0, 8'h08, 8'hF7, 3'd3, 1'b1};
      vecs[4]  = '{1'b0, 8'h08, 8'hFF, 3'd3, 1'b0};
      vecs[5]  = '{1'b0, 8'h08, 8'hF7, 3'd3, 1'b1};
      vecs[6]  = '{1'b0, 8'h08, 8'hF7, 3'd3, 1'b1};
      vecs[7]  = '{1'b0, 8'h08, 8'hF7, 3'd3, 1'b1};
      vecs[8]  = '{1'b0, 8'h08, 8'hF7, 3'd3, 1'b1};
      vecs[9]  = '{1'b0, 8'h08, 8'hFF, 3'd3, 1'b0};
      vecs[10] = '{1'b0, 8'h08, 8'hF7, 3'd3, 1'b1};
      // Requesters 0 and 7 alternate.
      vecs[11] = '{1'b1, 8'h81, 8'hFE, 3'd0, 1'b1};
      vecs[12] = '{1'b0, 8'h81, 8'hFE, 3'd0, 1'b1};
      vecs[13] = '{1'b0, 8'h81, 8'hFE, 3'd0, 1'b1};
      vecs[14] = '{1'b0, 8'h81, 8'hFE, 3'd0, 1'b1};
      vecs[15] = '{1'b0, 8'h81, 8'hFF, 3'd0, 1'b0};
      vecs[16] = '{1'b0, 8'h81, 8'h7F, 3'd7, 1'b1};
      vecs[17] = '{1'b0, 8'h81, 8'h7F, 3'd7, 1'b1};
      vecs[18] = '{1'b0, 8'h81, 8'h7F, 3'd7, 1'b1};
      vecs[19] = '{1'b0, 8'h81, 8'h7F, 3'd7, 1'b1};
      vecs[20] = '{1'b0, 8'h81, 8'hFF, 3'd7, 1'b0};
      vecs[21] = '{1'b0, 8'h81, 8'hFE, 3'd0, 1'b1};
      vecs[22] = '{1'b0, 8'h81, 8'hFE, 3'd0, 1'b1};

      $display("[TB] table vectors");
      for (int i = 0; i < 23; i++) begin
         if (vecs[i].rst) begin
            do_reset(vecs[i].req);
         end
         apply_stimulus(vecs[i].req);
         check_state($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].act);
      end

      $display("[TB] async reset mid-grant");
      do_reset(8'h08);
      apply_stimulus(8'h08);
      check_state("pre_clear", 8'hF7, 3'd3, 1'b1);
      #2;
      Clear_bar = 1'b0;
      #1;
      check_state("async_clear", 8'hFF, 3'd0, 1'b0);
      check_invariant();

      $display("[TB] early release");
      do_reset(8'h04);
      apply_stimulus(8'h04);
      check_state("er_grant2", 8'hFB, 3'd2, 1'b1);
      apply_stimulus(8'h02);
      check_state("er_guard", 8'hFF, 3'd2, 1'b0);
      apply_stimulus(8'h06);
      check_state("er_owner1", 8'hFD, 3'd1, 1'b1);
      apply_stimulus(8'h06);
      apply_stimulus(8'h06);
      apply_stimulus(8'h06);
      check_state("er_owner1_hold", 8'hFD, 3'd1, 1'b1);
      apply_stimulus(8'h06);
      check_state("er_guard2", 8'hFF, 3'd1, 1'b0);
      apply_stimulus(8'h06);
      check_state("er_owner2", 8'hFB, 3'd2, 1'b1);

      $display("[TB] wrap and idle");
      do_reset(8'h80);
      apply_stimulus(8'h80);
      check_state("wi_grant7", 8'h7F, 3'd7, 1'b1);
      apply_stimulus(8'h00);
      check_state("wi_guard", 8'hFF, 3'd7, 1'b0);
      apply_stimulus(8'h00);
      check_state("wi_idle", 8'hFF, 3'd7, 1'b0);
      apply_stimulus(8'h00);
      check_state("wi_idle2", 8'hFF, 3'd7, 1'b0);
      apply_stimulus(8'h01);
      check_state("wi_grant0", 8'hFE, 3'd0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
